// File: rtl/word_narrow.sv
// rtl/word_narrow.sv - stream width-down converter (IN_W -> OUT_W chunks); define WORD_NARROW_CNT_EN for word/packet counters
module word_narrow #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_W-1:0]                   out_data,
  output logic                               out_last,
  output logic [$clog2(IN_W/OUT_W)-1:0]      out_idx
`ifdef WORD_NARROW_CNT_EN
  ,
  output logic [15:0]                        word_cnt,
  output logic [7:0]                         pkt_cnt
`endif
);

  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic              live_q;     // low during reset and the first cycle after it
  logic [IN_W-1:0]   shreg_q;    // current chunk always sits at the output end
  logic              last_q;
  logic [IDX_W-1:0]  idx_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic [IN_W-1:0]   shreg_d;
  logic [IDX_W-1:0]  idx_d;
  logic              at_last;
  logic              out_fire;
  logic              in_fire;

  assign idx_d    = idx_q + IDX_W'(1);
  assign at_last  = (idx_q == LAST_IDX);
  assign out_fire = out_valid_q && out_ready;
  assign in_ready = live_q && ((state_q == IDLE) || (out_fire && at_last));
  assign in_fire  = in_valid && in_ready;

  // Chunk order is fixed at elaboration: shift toward the end that feeds out_data.
  if (MSB_FIRST != 0) begin : g_msb
    assign out_data = shreg_q[IN_W-1 -: OUT_W];
    assign shreg_d  = shreg_q << OUT_W;
  end else begin : g_lsb
    assign out_data = shreg_q[OUT_W-1:0];
    assign shreg_d  = shreg_q >> OUT_W;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;

  // IDLE/BUSY sequencer: load a word, walk its chunks, reload on the final chunk if another word waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      shreg_q     <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            state_q     <= BUSY;
            shreg_q     <= in_data;
            last_q      <= in_last;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        BUSY: begin
          if (out_fire) begin
            if (!at_last) begin
              shreg_q    <= shreg_d;
              idx_q      <= idx_d;
              out_last_q <= last_q && (idx_d == LAST_IDX);
            end else if (in_fire) begin
              // Back-to-back word: no bubble between the last chunk and the next first chunk.
              shreg_q     <= in_data;
              last_q      <= in_last;
              idx_q       <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end else begin
              state_q     <= IDLE;
              shreg_q     <= '0;
              last_q      <= 1'b0;
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          idx_q       <= '0;
        end
      endcase
    end
  end

`ifdef WORD_NARROW_CNT_EN
  // Count completed words and completed packets; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (out_fire && at_last) begin
      word_cnt <= word_cnt + 16'd1;
      if (out_last_q) begin
        pkt_cnt <= pkt_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_word_narrow.sv
// tb/tb_word_narrow.sv - directed scoreboard bench for word_narrow at three configurations
module tb_word_narrow;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic iv0, ir0, il0, ov0, or0, ol0;
  logic [7:0] id0;
  logic [3:0] od0;
  logic [0:0] ox0;
  logic iv1, ir1, il1, ov1, or1, ol1;
  logic [7:0] id1;
  logic [3:0] od1;
  logic [0:0] ox1;
  logic iv2, ir2, il2, ov2, or2, ol2;
  logic [11:0] id2;
  logic [3:0] od2;
  logic [1:0] ox2;
`ifdef WORD_NARROW_CNT_EN
  logic [15:0] wc0, wc1, wc2;
  logic [7:0]  pc0, pc1, pc2;
`endif

  word_narrow #(.IN_W(8), .OUT_W(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_last(il0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_last(ol0), .out_idx(ox0)
`ifdef WORD_NARROW_CNT_EN
    , .word_cnt(wc0), .pkt_cnt(pc0)
`endif
  );

  word_narrow #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_last(il1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1), .out_idx(ox1)
`ifdef WORD_NARROW_CNT_EN
    , .word_cnt(wc1), .pkt_cnt(pc1)
`endif
  );

  word_narrow #(.IN_W(12), .OUT_W(4), .MSB_FIRST(0)) u_w12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_last(il2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_last(ol2), .out_idx(ox2)
`ifdef WORD_NARROW_CNT_EN
    , .word_cnt(wc2), .pkt_cnt(pc2)
`endif
  );

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected chunk of one instance and compare it with what was transferred.
  task automatic score(input int which, input logic [3:0] d, input logic [1:0] idx, input logic last);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    checks++;
    assert (sz != 0) else begin
      errors++;
      $error("FAIL dut%0d_spurious: observed chunk 0x%0h with no expected entry", which, d);
    end
    if (sz != 0) begin
      case (which)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("dut%0d_data", which), 32'(d), 32'(e.d));
      chk($sformatf("dut%0d_idx", which), 32'(idx), 32'(e.idx));
      chk($sformatf("dut%0d_last", which), 32'(last), 32'(e.last));
    end
  endtask

  always @(negedge clk) if (rst_n === 1'b1 && ov0 && or0) score(0, od0, {1'b0, ox0}, ol0);
  always @(negedge clk) if (rst_n === 1'b1 && ov1 && or1) score(1, od1, {1'b0, ox1}, ol1);
  always @(negedge clk) if (rst_n === 1'b1 && ov2 && or2) score(2, od2, ox2, ol2);

  // Call at posedge+1. Offers a word, pushes its expected chunks, returns at posedge+1 after the transfer.
  task automatic send(input int which, input logic [11:0] data, input logic last, input bit hold,
                      output int waited);
    int   nch;
    int   sel;
    int   n;
    exp_t e;
    logic rdy;
    nch = (which == 2) ? 3 : 2;
    for (int k = 0; k < nch; k++) begin
      sel    = (which == 1) ? (nch - 1 - k) : k;
      e.d    = data[sel*4 +: 4];
      e.idx  = 2'(k);
      e.last = last && (k == nch - 1);
      case (which)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    case (which)
      0:       begin iv0 = 1'b1; id0 = data[7:0]; il0 = last; end
      1:       begin iv1 = 1'b1; id1 = data[7:0]; il1 = last; end
      default: begin iv2 = 1'b1; id2 = data;      il2 = last; end
    endcase
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      rdy = (which == 0) ? ir0 : (which == 1) ? ir1 : ir2;
      if (rdy) break;
    end
    waited = n;
    if (n >= 50) chk($sformatf("dut%0d_send_timeout", which), 32'(n < 50), 32'd1);
    step();
    if (!hold) begin
      case (which)
        0:       iv0 = 1'b0;
        1:       iv1 = 1'b0;
        default: iv2 = 1'b0;
      endcase
    end
  endtask

  // Wait until every expected chunk has been seen and all outputs are idle.
  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && !ov0 && !ov1 && !ov2) break;
    end
    chk("drain_complete", 32'(n < 100), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    iv0 = 0; il0 = 0; id0 = '0; or0 = 1'b1;
    iv1 = 0; il1 = 0; id1 = '0; or1 = 1'b1;
    iv2 = 0; il2 = 0; id2 = '0; or2 = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", 32'(od0), 32'd0);
    chk("rst_out_last", 32'(ol0), 32'd0);
    chk("rst_out_idx", 32'(ox0), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    step();

    // 0xA5, LSB first, cycle-exact
    send(0, 12'h0A5, 1'b1, 1'b0, w);
    chk("t1_accept_wait", 32'(w), 32'd0);
    @(negedge clk);
    chk("t1_c1_valid", 32'(ov0), 32'd1);
    chk("t1_c1_data", 32'(od0), 32'h5);
    chk("t1_c1_idx", 32'(ox0), 32'd0);
    chk("t1_c1_last", 32'(ol0), 32'd0);
    @(negedge clk);
    chk("t1_c2_data", 32'(od0), 32'hA);
    chk("t1_c2_idx", 32'(ox0), 32'd1);
    chk("t1_c2_last", 32'(ol0), 32'd1);
    @(negedge clk);
    chk("t1_c3_valid", 32'(ov0), 32'd0);
    chk("t1_c3_in_ready", 32'(ir0), 32'd1);
    step();

    // Back-to-back 0x12, 0x34 with no bubble
    send(0, 12'h012, 1'b0, 1'b1, w);
    send(0, 12'h034, 1'b1, 1'b0, w);
    chk("b2b_ready_on_second_chunk", 32'(w), 32'd1);
    @(negedge clk);
    chk("b2b_c3_data", 32'(od0), 32'h4);
    chk("b2b_c3_idx", 32'(ox0), 32'd0);
    @(negedge clk);
    chk("b2b_c4_data", 32'(od0), 32'h3);
    chk("b2b_c4_last", 32'(ol0), 32'd1);
    drain();

    // Backpressure on 0xC3
    or0 = 1'b0;
    send(0, 12'h0C3, 1'b0, 1'b0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ov0), 32'd1);
      chk("stall_data", 32'(od0), 32'h3);
      chk("stall_idx", 32'(ox0), 32'd0);
      chk("stall_in_ready", 32'(ir0), 32'd0);
    end
    step();
    or0 = 1'b1;
    drain();
`ifdef WORD_NARROW_CNT_EN
    chk("cnt_words_before_rst", 32'(wc0), 32'd4);
    chk("cnt_pkts_before_rst", 32'(pc0), 32'd2);
`endif

    // MSB-first instance and the 12-bit instance
    send(1, 12'h0A5, 1'b1, 1'b0, w);
    drain();
    send(2, 12'hABC, 1'b1, 1'b0, w);
    drain();
`ifdef WORD_NARROW_CNT_EN
    chk("w12_word_cnt", 32'(wc2), 32'd1);
    chk("w12_pkt_cnt", 32'(pc2), 32'd1);
`endif

    // Reset in the middle of 0x5F
    send(0, 12'h05F, 1'b1, 1'b0, w);
    @(negedge clk);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov0), 32'd0);
    chk("midrst_data", 32'(od0), 32'd0);
    chk("midrst_last", 32'(ol0), 32'd0);
    chk("midrst_idx", 32'(ox0), 32'd0);
    chk("midrst_discarded_pending", 32'(q0.size()), 32'd1);
    q0.delete();
`ifdef WORD_NARROW_CNT_EN
    chk("midrst_word_cnt", 32'(wc0), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    send(0, 12'h021, 1'b0, 1'b0, w);
    drain();
`ifdef WORD_NARROW_CNT_EN
    chk("after_rst_word_cnt", 32'(wc0), 32'd1);
    chk("after_rst_pkt_cnt", 32'(pc0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_narrow.md
Name: word_narrow

Overview:
- Stream width-down converter. Accepts IN_W-bit words on a valid/ready input and emits them as IN_W/OUT_W consecutive OUT_W-bit chunks on a valid/ready output.
- It is the counterpart of the widening path, where narrow signals are extended into wide ones. This block splits wide values back into narrow beats.
- Instantiated with parameter overrides from a parent module, and exercised at different widths.

Parameters:
- IN_W, 8: input word width. Must be an integer multiple of OUT_W and at least 2*OUT_W.
- OUT_W, 4: output chunk width.
- MSB_FIRST, 0: 0 emits the least-significant chunk first; 1 emits the most-significant chunk first.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_W  input word.
- in_last  input  1  marks the final word of a packet.
- out_valid  output  1  chunk offered.
- out_ready  input  1  downstream accepts the chunk.
- out_data  output  OUT_W  current chunk.
- out_last  output  1  final chunk of a word that arrived with in_last=1.
- out_idx  output  clog2(N)  index of the current chunk within its word, 0..N-1, where N=IN_W/OUT_W.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_idx=0, shift register=0, state=IDLE. in_ready=1 one cycle after rst_n deasserts.
- Handshakes: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready.
- States: IDLE and BUSY.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On an input transfer: latch in_data and in_last, set idx=0, go to BUSY.
- BUSY:
  - out_valid=1.
  - out_data is chunk idx. With MSB_FIRST=0 this is bits [idx*OUT_W +: OUT_W]; with MSB_FIRST=1 it is bits [(N-1-idx)*OUT_W +: OUT_W].
  - out_idx=idx.
  - out_last = latched_last && (idx==N-1).
- Output transfer with idx<N-1: idx increments.
- Output transfer with idx==N-1:
  - If in_valid is also high, the next word is loaded in the same cycle, idx returns to 0, and the block stays in BUSY.
  - Otherwise the block returns to IDLE.
- in_ready is combinational: in_ready = (state==IDLE) || (out_valid && out_ready && idx==N-1).
- Throughput: back-to-back words give one chunk per cycle with no bubbles.
- Latency: the first chunk is valid one cycle after the input transfer.
- Stall: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable, and in_ready=0.
- out_valid never drops without an output transfer.
- Data is treated as raw bits: no sign extension and no arithmetic.
- in_valid while in_ready=0 is ignored. No state change results.
- Asserting reset mid-word discards the word. No partial chunk appears after reset.

Optional Feature:
- Macro: WORD_NARROW_CNT_EN.
- Defined:
  - Adds output word_cnt [15:0], reset 0.
  - Increments on each output transfer with idx==N-1, wrapping 0xFFFF to 0x0000.
  - Adds output pkt_cnt [7:0], which increments when that transfer also has out_last=1, wrapping at 0xFF.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Defaults, send 0xA5 with in_last=1 and out_ready=1:
  - Cycle 1: out_data=0x5, idx=0, out_last=0.
  - Cycle 2: out_data=0xA, idx=1, out_last=1.
  - Cycle 3: out_valid=0.
- MSB_FIRST=1, send 0xA5: output is 0xA then 0x5.
- Back-to-back 0x12 then 0x34 with out_ready held at 1:
  - Output is 0x2, 0x1, 0x4, 0x3 on four consecutive cycles.
  - in_ready=1 on the cycle 0x1 is accepted.
- Backpressure: send 0xC3, hold out_ready=0 for 3 cycles.
  - out_data stays 0x3, idx stays 0 and in_ready stays 0 throughout.
  - After release, output is 0x3 then 0xC.
- IN_W=12, OUT_W=4, send 0xABC with in_last=1: output is 0xC, 0xB, 0xA, with out_last only on 0xA.
- Reset after the first chunk of 0x5F:
  - All outputs are 0 immediately.
  - A next word 0x21 then yields 0x1, 0x2.
  - With WORD_NARROW_CNT_EN, word_cnt=1 afterwards.
